// File: rtl/coh_avg_pkg.sv
// Shared state encoding and constants for the coherent averaging controller.
// Consumers select the signed sample format with the COH_AVG_SIGNED_EN macro.
package coh_avg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        DONE
    } state_t;

    // Shortest frame that keeps each read of an address behind its previous write-back.
    localparam int MIN_M = 4;

    localparam int PIPE_LAT = 3;

    function automatic int acc_width(input int dw, input int nw);
        return dw + nw;
    endfunction

endpackage

// File: rtl/coh_avg_rmw_pipe.sv
// Read-modify-write pipeline: extends a sample, adds the stored word and writes back the sum.
// COH_AVG_SIGNED_EN selects sign extension of the sample; otherwise it is zero-extended.
module coh_avg_rmw_pipe
    import coh_avg_pkg::*;
#(
    parameter int DW    = 14,
    parameter int AW    = 10,
    parameter int ACC_W = 30
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_addr,
    input  logic [DW-1:0]    issue_data,
    input  logic             issue_first,
    input  logic [ACC_W-1:0] ram_rdata,
    output logic             ram_we,
    output logic [AW-1:0]    ram_waddr,
    output logic [ACC_W-1:0] ram_wdata,
    output logic             in_flight
);

    logic [PIPE_LAT-1:0] vld;
    logic [AW-1:0]       addr_q [PIPE_LAT];
    logic [DW-1:0]       data0;
    logic                first0;
    logic [ACC_W-1:0]    ext_data0;
    logic [ACC_W-1:0]    ext1;
    logic [ACC_W-1:0]    addend1;
    logic [ACC_W-1:0]    sum2;

`ifdef COH_AVG_SIGNED_EN
    assign ext_data0 = {{(ACC_W-DW){data0[DW-1]}}, data0};
`else
    assign ext_data0 = {{(ACC_W-DW){1'b0}}, data0};
`endif

    // The RAM answers one cycle after the read, so the sample waits in stage 0 for it.
    // The first frame adds zero instead of stale RAM contents.
    // After extension the two's-complement add serves both the signed and unsigned builds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld     <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                addr_q[i] <= '0;
            end
            data0   <= '0;
            first0  <= 1'b0;
            ext1    <= '0;
            addend1 <= '0;
            sum2    <= '0;
        end else begin
            vld       <= {vld[PIPE_LAT-2:0], issue_valid};
            addr_q[0] <= issue_addr;
            for (int i = 1; i < PIPE_LAT; i++) begin
                addr_q[i] <= addr_q[i-1];
            end
            data0   <= issue_data;
            first0  <= issue_first;
            ext1    <= ext_data0;
            addend1 <= first0 ? '0 : ram_rdata;
            sum2    <= ext1 + addend1;
        end
    end

    assign ram_we    = vld[PIPE_LAT-1];
    assign ram_waddr = addr_q[PIPE_LAT-1];
    assign ram_wdata = sum2;

    // The final stage commits on the coming edge, so only the earlier stages hold off completion.
    assign in_flight = |vld[PIPE_LAT-2:0];

endmodule

// File: rtl/coherent_avg_ctrl.sv
// Coherent averaging controller: sums N frames of M samples into an external RAM.
// Define COH_AVG_SIGNED_EN for two's-complement samples; the default build is unsigned.
module coherent_avg_ctrl
    import coh_avg_pkg::*;
#(
    parameter int DW    = 14,
    parameter int AW    = 10,
    parameter int NW    = 16,
    parameter int ACC_W = acc_width(DW, NW)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [AW:0]      m_len,
    input  logic [NW-1:0]    n_frames,
    input  logic [DW-1:0]    s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [AW-1:0]    ram_raddr,
    input  logic [ACC_W-1:0] ram_rdata,
    output logic [AW-1:0]    ram_waddr,
    output logic [ACC_W-1:0] ram_wdata,
    output logic             ram_we,
    output logic             busy,
    output logic             done,
    output logic [NW-1:0]    frame_cnt
);

    localparam logic [AW:0] M_MIN = (AW+1)'(MIN_M);
    localparam logic [AW:0] M_MAX = {1'b1, {AW{1'b0}}};

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] m_last;
    logic [NW-1:0] n_q;
    logic [AW-1:0] idx;
    logic [AW:0]   m_eff;
    logic          load;
    logic          accept;
    logic          wrap;
    logic          in_flight;

    // Frames shorter than MIN_M would read an address before its write-back lands.
    always_comb begin
        m_eff = m_len;
        if (m_len < M_MIN) begin
            m_eff = M_MIN;
        end else if (m_len > M_MAX) begin
            m_eff = M_MAX;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        accept   = 1'b0;
        wrap     = 1'b0;
        s_ready  = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = ACCUM;
                end
            end
            ACCUM: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                accept  = s_valid;
                wrap    = accept && (idx == m_last);
                if (wrap && (frame_cnt + NW'(1) == n_q)) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (!in_flight) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_last    <= '0;
            n_q       <= '0;
            idx       <= '0;
            frame_cnt <= '0;
        end else if (load) begin
            m_last    <= AW'(m_eff - (AW+1)'(1));
            n_q       <= n_frames;
            idx       <= '0;
            frame_cnt <= '0;
        end else if (accept) begin
            if (wrap) begin
                idx       <= '0;
                frame_cnt <= frame_cnt + NW'(1);
            end else begin
                idx <= idx + AW'(1);
            end
        end
    end

    assign ram_raddr = idx;

    coh_avg_rmw_pipe #(
        .DW    (DW),
        .AW    (AW),
        .ACC_W (ACC_W)
    ) u_pipe (
        .clk         (clk),
        .reset_n     (reset_n),
        .issue_valid (accept),
        .issue_addr  (idx),
        .issue_data  (s_data),
        .issue_first (frame_cnt == '0),
        .ram_rdata   (ram_rdata),
        .ram_we      (ram_we),
        .ram_waddr   (ram_waddr),
        .ram_wdata   (ram_wdata),
        .in_flight   (in_flight)
    );

endmodule

// File: tb/tb_coherent_avg_ctrl.sv
// Self-checking bench for coherent_avg_ctrl: table of averaging runs against a behavioural RAM,
// plus hand sequences for reset state, mid-run reset and ignored start pulses.
module tb_coherent_avg_ctrl;

    localparam int DW    = 14;
    localparam int AW    = 10;
    localparam int NW    = 16;
    localparam int ACC_W = 30;
    localparam int DEPTH = 1 << AW;
    localparam int LIMIT = 5000;

`ifdef COH_AVG_SIGNED_EN
    localparam logic [63:0] SGN_W0 = 64'h3FFF_E001;
`else
    localparam logic [63:0] SGN_W0 = 64'd8193;
`endif

    typedef struct {
        logic [AW:0]   m_len;
        logic [NW-1:0] n;
        int            base;
        bit            gap;
        bit            poke;
        bit            sgn;
        int            exp_m;
        int            exp_writes;
        logic [63:0]   exp_w0;
        logic [63:0]   exp_wl;
    } run_t;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic [AW:0]      m_len = '0;
    logic [NW-1:0]    n_frames = '0;
    logic [DW-1:0]    s_data = '0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [AW-1:0]    ram_raddr;
    logic [ACC_W-1:0] ram_rdata = '0;
    logic [AW-1:0]    ram_waddr;
    logic [ACC_W-1:0] ram_wdata;
    logic             ram_we;
    logic             busy;
    logic             done;
    logic [NW-1:0]    frame_cnt;

    logic [ACC_W-1:0] mem [DEPTH];
    logic             fill = 1'b0;
    logic [DEPTH-1:0] pending = '0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int wr_count = 0;
    int acc_count = 0;
    int done_count = 0;
    int hazards = 0;
    int last_wr_cyc = 0;
    int done_cyc = 0;

    run_t runs [7];

    always #5 clk = ~clk;

    coherent_avg_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .m_len     (m_len),
        .n_frames  (n_frames),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .busy      (busy),
        .done      (done),
        .frame_cnt (frame_cnt)
    );

    // Accumulation RAM with registered read; fill plants junk so frame 0 must ignore old contents.
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= ACC_W'(32'h0ABC_0000 + i);
            end
        end else if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_raddr];
    end

    // Observes mid-cycle: counts accepts and writes, and flags a read of an address whose write is outstanding.
    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            pending = '0;
        end else begin
            if (s_valid && s_ready) begin
                acc_count++;
                if (pending[ram_raddr]) hazards++;
            end
            if (ram_we) begin
                wr_count++;
                last_wr_cyc = cyc;
                pending[ram_waddr] = 1'b0;
            end
            if (s_valid && s_ready) pending[ram_raddr] = 1'b1;
            if (done) begin
                done_count++;
                done_cyc = cyc;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] sample(input run_t r, input int n);
        int k;
        int f;
        k = n % r.exp_m;
        f = n / r.exp_m;
        if (r.sgn) begin
            if (k != 0) return '0;
            return (f == 0) ? 14'h2000 : 14'd1;
        end
        return DW'(r.base + k);
    endfunction

    function automatic logic [63:0] model_word(input run_t r, input int k);
        if (r.sgn) return (k == 0) ? r.exp_w0 : 64'd0;
        return 64'(r.n) * 64'(r.base + k);
    endfunction

    task automatic applyStimulus(input run_t r);
        int wr0, acc0, dn0, hz0, cycles, badw;
        fill = 1'b1;
        @(posedge clk); #1;
        fill = 1'b0;
        wr0  = wr_count;
        acc0 = acc_count;
        dn0  = done_count;
        hz0  = hazards;
        m_len    = r.m_len;
        n_frames = r.n;
        start    = 1'b1;
        checkOutput("busy_idle_at_start", 64'(busy), 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("busy_after_start", 64'(busy), 64'd1);
        cycles = 0;
        while (!done && cycles < LIMIT) begin
            s_valid  = r.gap ? (cycles % 2 == 0) : 1'b1;
            s_data   = sample(r, acc_count - acc0);
            start    = r.poke && (cycles == 3);
            m_len    = (r.poke && cycles == 3) ? (AW+1)'(16) : r.m_len;
            n_frames = (r.poke && cycles == 3) ? NW'(9) : r.n;
            @(posedge clk); #1;
            cycles++;
        end
        checkOutput("run_reached_done", 64'(done), 64'd1);
        s_valid = 1'b0;
        checkOutput("busy_low_in_done", 64'(busy), 64'd0);
        if (r.poke) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        if (r.poke) checkOutput("start_in_done_ignored", 64'(busy), 64'd0);
        checkOutput("accepted", 64'(acc_count - acc0), 64'(r.exp_writes));
        checkOutput("writes", 64'(wr_count - wr0), 64'(r.exp_writes));
        checkOutput("done_pulses", 64'(done_count - dn0), 64'd1);
        checkOutput("done_after_last_we", 64'(done_cyc - last_wr_cyc), 64'd1);
        checkOutput("frame_cnt", 64'(frame_cnt), 64'(r.n));
        checkOutput("hazards", 64'(hazards - hz0), 64'd0);
        checkOutput("word0", 64'(mem[0]), r.exp_w0);
        checkOutput("word_last", 64'(mem[r.exp_m-1]), r.exp_wl);
        badw = 0;
        for (int k = 0; k < r.exp_m; k++) begin
            if (64'(mem[k]) !== model_word(r, k)) badw++;
        end
        checkOutput("all_words", 64'(badw), 64'd0);
    endtask

    initial begin
        //          m_len     n      base gap poke sgn  M     writes  word0       word M-1
        runs[0] = '{11'd4,    16'd1, 1,   0,  0,   0,   4,    4,      64'd1,      64'd4};
        runs[1] = '{11'd8,    16'd3, 10,  0,  0,   0,   8,    24,     64'd30,     64'd51};
        runs[2] = '{11'd2,    16'd2, 5,   0,  0,   0,   4,    8,      64'd10,     64'd16};
        runs[3] = '{11'd4,    16'd2, 7,   1,  1,   0,   4,    8,      64'd14,     64'd20};
        runs[4] = '{11'd4,    16'd2, 0,   0,  0,   1,   4,    8,      SGN_W0,     64'd0};
        runs[5] = '{11'd1500, 16'd1, 0,   0,  0,   0,   1024, 1024,   64'd0,      64'd1023};
        runs[6] = '{11'd0,    16'd2, 100, 0,  0,   0,   4,    8,      64'd200,    64'd206};

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ram_we", 64'(ram_we), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_s_ready", 64'(s_ready), 64'd0);
        checkOutput("reset_frame_cnt", 64'(frame_cnt), 64'd0);
        checkOutput("reset_raddr", 64'(ram_raddr), 64'd0);
        reset_n = 1'b1;

        // Abort a run with frame 1 under way and a write-back on the port.
        @(posedge clk); #1;
        m_len    = 11'd4;
        n_frames = 16'd3;
        start    = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        s_valid = 1'b1;
        s_data  = 14'd1;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("we_before_reset", 64'(ram_we), 64'd1);
        checkOutput("frame_cnt_before_reset", 64'(frame_cnt), 64'd1);
        #2;
        reset_n = 1'b0;
        s_valid = 1'b0;
        #1;
        checkOutput("we_after_reset", 64'(ram_we), 64'd0);
        checkOutput("busy_after_reset", 64'(busy), 64'd0);
        checkOutput("frame_cnt_after_reset", 64'(frame_cnt), 64'd0);
        checkOutput("s_ready_after_reset", 64'(s_ready), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            $display("[TB] run %0d: m_len=%0d n_frames=%0d", i, runs[i].m_len, runs[i].n);
            applyStimulus(runs[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
